execute_lsu_mc: RTL
===================

Name: execute_lsu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle LSU execute stage.
- Pops one memory op from the issue FIFO, checks alignment and sends stores to the store buffer.
- Runs loads through a request/response bus handshake, then sign- or zero-extends the data.
- Drives the writeback port and the bypass feedback channel; handles commit flush, including draining an in-flight load response.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, register/bus data width (32 or 64)
ROB_ID_WIDTH, 7, ROB id width
PHY_REG_ID_WIDTH, 6, physical register id width
EXC_ID_WIDTH, 5, exception id width
MISALIGN_CHECK, 1, 1 = raise misaligned exceptions; 0 = pass address through

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  issue FIFO head valid
issue_pop  out  1  head consumed this cycle (combinational)
issue_rob_id  in  ROB_ID_WIDTH  rob id of head
issue_op  in  3  0 lb,1 lh,2 lw,3 lbu,4 lhu,5 sb,6 sh,7 sw
issue_addr  in  ADDR_WIDTH  effective address
issue_src2  in  DATA_WIDTH  store data
issue_rd_phy  in  PHY_REG_ID_WIDTH  destination physical register
issue_rd_enable  in  1  destination written
issue_has_exception  in  1  upstream exception
issue_exception_id  in  EXC_ID_WIDTH  upstream exception id
bus_read_req  out  1  load request
bus_read_addr  out  ADDR_WIDTH  load address
bus_read_size  out  3  bytes: 1/2/4
bus_read_ready  in  1  request accepted
bus_rdata_valid  in  1  response valid
bus_rdata  in  DATA_WIDTH  response data, low-aligned
stbuf_push  out  1  store push (combinational)
stbuf_rob_id  out  ROB_ID_WIDTH  store rob id
stbuf_addr  out  ADDR_WIDTH  store address
stbuf_size  out  3  store bytes
stbuf_data  out  DATA_WIDTH  store data, zero-masked to size
stbuf_full  in  1  store buffer full
flush  in  1  commit flush
wb_we  out  1  writeback valid (registered)
wb_flush  out  1  = ~wb_we (registered)
wb_rob_id  out  ROB_ID_WIDTH  writeback rob id
wb_rd_value  out  DATA_WIDTH  load result
wb_has_exception  out  1  exception flag
wb_exception_id  out  EXC_ID_WIDTH  exception id
wb_exception_value  out  ADDR_WIDTH  faulting address
fb_enable  out  1  bypass valid (registered)
fb_phy_id  out  PHY_REG_ID_WIDTH  bypass register
fb_value  out  DATA_WIDTH  bypass value

Behaviour:
- States: IDLE, LOAD_REQ, LOAD_WAIT, DRAIN.
- Reset: state IDLE; wb_we=0, wb_flush=1, fb_enable=0; all registered data outputs 0; bus_read_req=0.
- issue_pop and stbuf_push are 0 in any state other than IDLE, and 0 whenever flush=1.
- Misaligned: lh/lhu/sh with addr[0]!=0, or lw/sw with addr[1:0]!=0. Only checked when MISALIGN_CHECK=1.

IDLE, issue_valid=1 and flush=0, one of these per cycle in priority order:
- Upstream exception: pop=1. Next cycle: wb_we=1, exception fields copied, exception_value=0.
- Misaligned access: pop=1. Next cycle: wb_we=1, id 4 for loads / 6 for stores, exception_value=issue_addr.
- Store:
  - stbuf_full=1: pop=0, push=0, no writeback.
  - Otherwise: pop=1, push=1 the same cycle; stbuf_data=src2 masked to 8/16/32 bits; size 1/2/4.
  - Next cycle: wb_we=1, no exception, fb_enable=0.
- Load: pop=1; latch rob_id, op, addr, rd_phy, rd_enable; go to LOAD_REQ.

Load handshake:
- LOAD_REQ: bus_read_req=1 with the latched addr/size. On bus_read_ready go to LOAD_WAIT.
- LOAD_WAIT: on bus_rdata_valid, extend the data and go to IDLE.
  - Extension: lb/lh/lw sign-extend from bit 7/15/31; lbu/lhu zero-extend.
  - Next cycle: wb_we=1, wb_rd_value=result. If rd_enable=1, also fb_enable=1 with fb_phy_id=rd_phy and fb_value=result.
- Minimum load latency: pop at T, request at T+1, data at T+2, writeback at T+3.
- A new op may be popped in the same cycle the writeback registers present the previous result.

Flush (highest priority):
- Next cycle: wb_we=0, wb_flush=1, fb_enable=0.
- State transitions on flush:
  - LOAD_REQ with bus_read_ready=0 → IDLE.
  - LOAD_REQ with bus_read_ready=1 → DRAIN.
  - LOAD_WAIT with bus_rdata_valid=0 → DRAIN.
  - LOAD_WAIT with bus_rdata_valid=1 → IDLE, data discarded.
  - IDLE → IDLE, nothing popped.
- DRAIN: wait for bus_rdata_valid, discard it, go to IDLE. No writeback; flush inside DRAIN keeps DRAIN.

Other rules:
- Any idle cycle produces wb_we=0, wb_flush=1 the next cycle.
- Reset mid-load: return to IDLE immediately. The bus is reset concurrently.

Test Plan:
1. Reset, then issue_valid=0 for two cycles → wb_we=0, wb_flush=1, issue_pop=0, fb_enable=0, bus_read_req=0.
2. issue_has_exception=1, id=2, issue_valid=1 → pop=1; next cycle wb_we=1, wb_has_exception=1, wb_exception_id=2.
3. lh at addr 0x1001 → pop=1, no bus_read_req; next cycle wb_exception_id=4, wb_exception_value=0x1001. Repeat with MISALIGN_CHECK=0 → a normal load is issued.
4. lb at addr 0x40, rd_phy=10, rd_enable=1; ready held 1; rdata=0x000000F0 two cycles after pop → wb_rd_value=0xFFFFFFF0, fb_enable=1, fb_phy_id=10, fb_value=0xFFFFFFF0. Repeat as lbu → 0x000000F0.
5. sh rob_id=7, addr 0xAACCBEEE, src2=0xDEADBEEF, stbuf_full=1 → pop=0, push=0. Drop full → push=1, size=2, data=0x0000BEEF, rob_id=7; next cycle wb_we=1.
6. lw accepted (ready=1), then flush in LOAD_WAIT before data → DRAIN. Late rdata=0x12345678 → wb_we stays 0, fb_enable=0, return to IDLE. The next lw completes normally.

Source files
------------

// File: rtl/execute_lsu_mc.sv
// execute_lsu_mc: multi-cycle load/store execute stage with bus handshake, store-buffer push,
// writeback/bypass outputs and flush draining.  Rev 1.0
`default_nettype none

module execute_lsu_mc #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int ROB_ID_WIDTH     = 7,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int EXC_ID_WIDTH     = 5,
  parameter bit MISALIGN_CHECK   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  output logic                        issue_pop,
  input  logic [ROB_ID_WIDTH-1:0]     issue_rob_id,
  input  logic [2:0]                  issue_op,
  input  logic [ADDR_WIDTH-1:0]       issue_addr,
  input  logic [DATA_WIDTH-1:0]       issue_src2,
  input  logic [PHY_REG_ID_WIDTH-1:0] issue_rd_phy,
  input  logic                        issue_rd_enable,
  input  logic                        issue_has_exception,
  input  logic [EXC_ID_WIDTH-1:0]     issue_exception_id,
  output logic                        bus_read_req,
  output logic [ADDR_WIDTH-1:0]       bus_read_addr,
  output logic [2:0]                  bus_read_size,
  input  logic                        bus_read_ready,
  input  logic                        bus_rdata_valid,
  input  logic [DATA_WIDTH-1:0]       bus_rdata,
  output logic                        stbuf_push,
  output logic [ROB_ID_WIDTH-1:0]     stbuf_rob_id,
  output logic [ADDR_WIDTH-1:0]       stbuf_addr,
  output logic [2:0]                  stbuf_size,
  output logic [DATA_WIDTH-1:0]       stbuf_data,
  input  logic                        stbuf_full,
  input  logic                        flush,
  output logic                        wb_we,
  output logic                        wb_flush,
  output logic [ROB_ID_WIDTH-1:0]     wb_rob_id,
  output logic [DATA_WIDTH-1:0]       wb_rd_value,
  output logic                        wb_has_exception,
  output logic [EXC_ID_WIDTH-1:0]     wb_exception_id,
  output logic [ADDR_WIDTH-1:0]       wb_exception_value,
  output logic                        fb_enable,
  output logic [PHY_REG_ID_WIDTH-1:0] fb_phy_id,
  output logic [DATA_WIDTH-1:0]       fb_value
);

  localparam logic [EXC_ID_WIDTH-1:0] EXC_LOAD_MISALIGN  = EXC_ID_WIDTH'(4);
  localparam logic [EXC_ID_WIDTH-1:0] EXC_STORE_MISALIGN = EXC_ID_WIDTH'(6);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_REQ  = 2'd1,
    S_LOAD_WAIT = 2'd2,
    S_DRAIN     = 2'd3
  } state_t;

  state_t                      state_q;
  logic [ROB_ID_WIDTH-1:0]     ld_rob_q;
  logic [2:0]                  ld_op_q;
  logic [ADDR_WIDTH-1:0]       ld_addr_q;
  logic [PHY_REG_ID_WIDTH-1:0] ld_phy_q;
  logic                        ld_rd_en_q;

  logic       is_store_w;
  logic [2:0] size_w;
  logic       misalign_w;
  logic [DATA_WIDTH-1:0] load_result_w;

  function automatic logic [2:0] op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd3, 3'd5: op_size = 3'd1;
      3'd1, 3'd4, 3'd6: op_size = 3'd2;
      default:          op_size = 3'd4;
    endcase
  endfunction

  assign is_store_w = (issue_op >= 3'd5);
  assign size_w     = op_size(issue_op);
  assign misalign_w = MISALIGN_CHECK &&
                      (((size_w == 3'd2) && issue_addr[0]) ||
                       ((size_w == 3'd4) && (issue_addr[1:0] != 2'b00)));

  // Exceptions and misaligned ops retire without touching the store buffer, so a full buffer only stalls clean stores.
  always_comb begin
    issue_pop  = 1'b0;
    stbuf_push = 1'b0;
    if (state_q == S_IDLE && issue_valid && !flush) begin
      if (issue_has_exception || misalign_w || !is_store_w) begin
        issue_pop = 1'b1;
      end else if (!stbuf_full) begin
        issue_pop  = 1'b1;
        stbuf_push = 1'b1;
      end
    end
  end

  always_comb begin
    stbuf_data = '0;
    case (size_w)
      3'd1:    stbuf_data[7:0]  = issue_src2[7:0];
      3'd2:    stbuf_data[15:0] = issue_src2[15:0];
      default: stbuf_data[31:0] = issue_src2[31:0];
    endcase
  end

  assign stbuf_rob_id = issue_rob_id;
  assign stbuf_addr   = issue_addr;
  assign stbuf_size   = size_w;

  always_comb begin
    case (ld_op_q)
      3'd0:    load_result_w = DATA_WIDTH'($signed(bus_rdata[7:0]));
      3'd1:    load_result_w = DATA_WIDTH'($signed(bus_rdata[15:0]));
      3'd3:    load_result_w = DATA_WIDTH'(bus_rdata[7:0]);
      3'd4:    load_result_w = DATA_WIDTH'(bus_rdata[15:0]);
      default: load_result_w = DATA_WIDTH'($signed(bus_rdata[31:0]));
    endcase
  end

  assign bus_read_req  = (state_q == S_LOAD_REQ);
  assign bus_read_addr = ld_addr_q;
  assign bus_read_size = op_size(ld_op_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      ld_rob_q           <= '0;
      ld_op_q            <= '0;
      ld_addr_q          <= '0;
      ld_phy_q           <= '0;
      ld_rd_en_q         <= 1'b0;
      wb_we              <= 1'b0;
      wb_flush           <= 1'b1;
      wb_rob_id          <= '0;
      wb_rd_value        <= '0;
      wb_has_exception   <= 1'b0;
      wb_exception_id    <= '0;
      wb_exception_value <= '0;
      fb_enable          <= 1'b0;
      fb_phy_id          <= '0;
      fb_value           <= '0;
    end else begin
      wb_we     <= 1'b0;
      wb_flush  <= 1'b1;
      fb_enable <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue_pop) begin
            if (issue_has_exception || misalign_w || is_store_w) begin
              wb_we              <= 1'b1;
              wb_flush           <= 1'b0;
              wb_rob_id          <= issue_rob_id;
              wb_rd_value        <= '0;
              wb_has_exception   <= issue_has_exception || misalign_w;
              wb_exception_id    <= issue_has_exception ? issue_exception_id :
                                    !misalign_w         ? '0 :
                                    is_store_w          ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
              wb_exception_value <= (!issue_has_exception && misalign_w) ? issue_addr : '0;
            end else begin
              ld_rob_q   <= issue_rob_id;
              ld_op_q    <= issue_op;
              ld_addr_q  <= issue_addr;
              ld_phy_q   <= issue_rd_phy;
              ld_rd_en_q <= issue_rd_enable;
              state_q    <= S_LOAD_REQ;
            end
          end
        end
        S_LOAD_REQ: begin
          if (bus_read_ready) begin
            state_q <= flush ? S_DRAIN : S_LOAD_WAIT;
          end else if (flush) begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD_WAIT: begin
          if (bus_rdata_valid) begin
            state_q <= S_IDLE;
            if (!flush) begin
              wb_we              <= 1'b1;
              wb_flush           <= 1'b0;
              wb_rob_id          <= ld_rob_q;
              wb_rd_value        <= load_result_w;
              wb_has_exception   <= 1'b0;
              wb_exception_id    <= '0;
              wb_exception_value <= '0;
              fb_enable          <= ld_rd_en_q;
              fb_phy_id          <= ld_phy_q;
              fb_value           <= load_result_w;
            end
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        default: begin
          // An accepted request always returns data; swallow it before taking new work.
          if (bus_rdata_valid) state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
